sr_drive_ctrl: RTL and testbench

- Upstream command stage for the team's clocked SR flip-flop.
- Accepts set/reset/toggle requests over a valid/ready handshake and converts each into a timed, single-sided S or R pulse.
- Never drives S and R high together, so the forbidden S=R=1 input can never reach the flip-flop.
- Keeps a shadow copy of the flip-flop's expected Q, which is used to resolve toggle commands.

---
 rtl/sr_drive_pkg.sv | 11 +
 rtl/sr_drive_ctrl_timer.sv | 18 +
 rtl/sr_drive_ctrl.sv | 91 +++++++++
 tb/tb_sr_drive_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sr_drive_pkg.sv
// sr_drive_pkg: op/state encodings and counter width shared by sr_drive_ctrl and its timer.
package sr_drive_pkg;
    localparam int CNT_W = 8;
    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_SET    = 2'b01,
        OP_RESET  = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;
    typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_GAP} state_e;
endpackage

// File: rtl/sr_drive_ctrl_timer.sv
// sr_pulse_timer: loadable down-counter that stops at zero and flags done; shared by PULSE and GAP phases.
module sr_pulse_timer
    import sr_drive_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - CNT_W'(1);
    end
    assign done = cnt == '0;
endmodule

// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: turns set/reset/toggle requests into exclusive timed S/R pulses and tracks expected Q.
// Optional SR_DRIVE_CHECK_EN adds q_fb feedback and a sticky mismatch flag.
module sr_drive_ctrl
    import sr_drive_pkg::*;
#(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    output logic       req_ready,
    output logic       s_out,
    output logic       r_out,
    output logic       busy,
`ifdef SR_DRIVE_CHECK_EN
    input  logic       q_fb,
    output logic       mismatch,
`endif
    output logic       q_shadow
);
    localparam logic [CNT_W-1:0] P_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] G_LD = CNT_W'((GAP_W == 0) ? 0 : GAP_W - 1);
    state_e state, state_nxt;
    logic dir, dir_nxt, s_nxt, r_nxt, q_nxt, ld, done;
    logic [CNT_W-1:0] ld_val;
    sr_pulse_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (ld),
        .load_val(ld_val),
        .done    (done)
    );
    assign req_ready = (state == ST_IDLE) && !rst;
    assign busy      = state != ST_IDLE;
    // dir = 1 means a SET pulse; toggles resolve against the shadow at the accept edge
    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        s_nxt     = 1'b0;
        r_nxt     = 1'b0;
        q_nxt     = q_shadow;
        ld        = 1'b0;
        ld_val    = P_LD;
        case (state)
            ST_IDLE: if (req_valid && req_op != OP_NOP) begin
                dir_nxt   = (req_op == OP_SET) || (req_op == OP_TOGGLE && !q_shadow);
                s_nxt     = dir_nxt;
                r_nxt     = !dir_nxt;
                ld        = 1'b1;
                state_nxt = ST_PULSE;
            end
            ST_PULSE: if (done) begin
                q_nxt     = dir;
                ld        = 1'b1;
                ld_val    = G_LD;
                state_nxt = (GAP_W == 0) ? ST_IDLE : ST_GAP;
            end else begin
                s_nxt = s_out;
                r_nxt = r_out;
            end
            ST_GAP: state_nxt = done ? ST_IDLE : ST_GAP;
            default: state_nxt = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            dir      <= 1'b0;
            s_out    <= 1'b0;
            r_out    <= 1'b0;
            q_shadow <= 1'b0;
        end else begin
            state    <= state_nxt;
            dir      <= dir_nxt;
            s_out    <= s_nxt;
            r_out    <= r_nxt;
            q_shadow <= q_nxt;
        end
    end
`ifdef SR_DRIVE_CHECK_EN
    if (GAP_W < 1) begin : g_gap_check
        $error("sr_drive_ctrl: feedback check needs GAP_W >= 1");
    end
    always_ff @(posedge clk) begin
        if (rst) mismatch <= 1'b0;
        else if (state == ST_GAP && done && q_fb != q_shadow) mismatch <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_sr_drive_ctrl.sv
// tb_sr_drive_ctrl: directed table plus random stimulus against a cycle-schedule model, two parameter sets.
module tb_sr_drive_ctrl;
    import sr_drive_pkg::*;
    localparam int G1 = `ifdef SR_DRIVE_CHECK_EN 1 `else 0 `endif;
    typedef struct packed {
        logic       rst;
        logic       v;
        logic [1:0] op;
        logic       s;
        logic       r;
        logic       q;
        logic       rdy;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0;
    logic [1:0] req_op = 2'b00;
    logic [1:0] s_o, r_o, b_o, q_o, rdy_o;
`ifdef SR_DRIVE_CHECK_EN
    logic fb_bad = 1'b0;
    logic [1:0] mm;
`endif
    int st[2];
    int pw[2];
    int gw[2];
    bit dir[2];
    bit q0[2];
    int cyc = 0, n_chk = 0, n_err = 0;
    vec_t tbl[$];
    always #5 clk = ~clk;
    sr_drive_ctrl #(.PULSE_W(2), .GAP_W(1)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_ready(rdy_o[0]),
        .s_out(s_o[0]), .r_out(r_o[0]), .busy(b_o[0]),
`ifdef SR_DRIVE_CHECK_EN
        .q_fb(fb_bad ? 1'b0 : q_o[0]), .mismatch(mm[0]),
`endif
        .q_shadow(q_o[0])
    );
    sr_drive_ctrl #(.PULSE_W(1), .GAP_W(G1)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_ready(rdy_o[1]),
        .s_out(s_o[1]), .r_out(r_o[1]), .busy(b_o[1]),
`ifdef SR_DRIVE_CHECK_EN
        .q_fb(q_o[1]), .mismatch(mm[1]),
`endif
        .q_shadow(q_o[1])
    );
    task automatic chk(string n, int a, int e);
        n_chk++;
        if (a != e) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", n, cyc, a, e);
        end
    endtask
    // Each command owns a window: pulse in [st, st+P), q flips at st+P, ready again from st+P+G.
    function automatic bit q_at(int d, int c);
        return (c >= st[d] + pw[d]) ? dir[d] : q0[d];
    endfunction
    function automatic bit rdy_at(int d, int c);
        return c >= st[d] + pw[d] + gw[d];
    endfunction
    task automatic step();
        for (int d = 0; d < 2; d++) begin
            bit qn;
            qn = q_at(d, cyc);
            if (rst) begin
                st[d] = -1000;
                dir[d] = 1'b0;
                q0[d] = 1'b0;
            end else if (req_valid && rdy_at(d, cyc) && req_op != OP_NOP) begin
                q0[d] = qn;
                dir[d] = (req_op == OP_SET) || (req_op == OP_TOGGLE && !qn);
                st[d] = cyc + 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            bit act;
            act = cyc >= st[d] && cyc < st[d] + pw[d];
            chk($sformatf("s_out%0d", d), int'(s_o[d]), int'(act && dir[d]));
            chk($sformatf("r_out%0d", d), int'(r_o[d]), int'(act && !dir[d]));
            chk($sformatf("q_shadow%0d", d), int'(q_o[d]), int'(q_at(d, cyc)));
            chk($sformatf("busy%0d", d), int'(b_o[d]), int'(cyc >= st[d] && cyc < st[d] + pw[d] + gw[d]));
            chk($sformatf("req_ready%0d", d), int'(rdy_o[d]), int'(!rst && rdy_at(d, cyc)));
            chk($sformatf("excl%0d", d), int'(s_o[d] & r_o[d]), 0);
        end
    endtask
    task automatic add(bit r_, bit v, logic [1:0] op, bit s, bit r, bit q, bit rdy);
        tbl.push_back({r_, v, op, s, r, q, rdy});
    endtask
    initial begin
        int pulses;
        st = '{-1000, -1000};
        pw = '{2, 1};
        gw = '{1, G1};
        //   rst v  op         s  r  q  rdy
        add(1, 0, OP_NOP,    0, 0, 0, 0);
        add(0, 0, OP_NOP,    0, 0, 0, 1);
        add(0, 1, OP_SET,    1, 0, 0, 0);
        add(0, 0, OP_NOP,    1, 0, 0, 0);
        add(0, 0, OP_NOP,    0, 0, 1, 0);
        add(0, 0, OP_NOP,    0, 0, 1, 1);
        add(0, 1, OP_NOP,    0, 0, 1, 1);
        add(0, 1, OP_SET,    1, 0, 1, 0);
        add(0, 0, OP_NOP,    1, 0, 1, 0);
        add(0, 0, OP_NOP,    0, 0, 1, 0);
        add(0, 1, OP_TOGGLE, 0, 0, 1, 1);
        add(0, 1, OP_TOGGLE, 0, 1, 1, 0);
        add(0, 1, OP_TOGGLE, 0, 1, 1, 0);
        add(0, 1, OP_TOGGLE, 0, 0, 0, 0);
        add(0, 1, OP_TOGGLE, 0, 0, 0, 1);
        add(0, 1, OP_TOGGLE, 1, 0, 0, 0);
        add(0, 0, OP_NOP,    1, 0, 0, 0);
        add(1, 0, OP_NOP,    0, 0, 0, 0);
        add(0, 0, OP_NOP,    0, 0, 0, 1);
        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            req_valid = tbl[i].v;
            req_op = tbl[i].op;
            step();
            chk($sformatf("tbl%0d_s", i), int'(s_o[0]), int'(tbl[i].s));
            chk($sformatf("tbl%0d_r", i), int'(r_o[0]), int'(tbl[i].r));
            chk($sformatf("tbl%0d_q", i), int'(q_o[0]), int'(tbl[i].q));
            chk($sformatf("tbl%0d_rdy", i), int'(rdy_o[0]), int'(tbl[i].rdy));
        end
        // Back-to-back SET/RESET alternation; the short-pulse instance accepts every 2+G1 cycles.
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            req_valid = 1'b1;
            req_op = ((i / (2 + G1)) % 2 == 1) ? OP_RESET : OP_SET;
            step();
            pulses += int'(s_o[1] | r_o[1]);
        end
        chk("alt_pulses", pulses, (12 + 1 + G1) / (2 + G1));
        for (int i = 0; i < 400; i++) begin
            rst = $urandom_range(0, 49) == 0;
            req_valid = ($urandom % 3) != 0;
            req_op = 2'($urandom % 4);
            step();
        end
`ifdef SR_DRIVE_CHECK_EN
        chk("mismatch_clean", int'(mm[0]), 0);
        rst = 1'b1;
        req_valid = 1'b0;
        step();
        rst = 1'b0;
        fb_bad = 1'b1;
        req_valid = 1'b1;
        req_op = OP_SET;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("mismatch_pre_gap_end", int'(mm[0]), 0);
        step();
        chk("mismatch_set", int'(mm[0]), 1);
        fb_bad = 1'b0;
        step();
        step();
        chk("mismatch_sticky", int'(mm[0]), 1);
        rst = 1'b1;
        step();
        chk("mismatch_rst", int'(mm[0]), 0);
        rst = 1'b0;
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
